// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass, sweep clear and a debug access port
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RPORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             i_rst,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] i_raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] o_rdata,
  input  logic [ADDR_WIDTH-1:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic                             i_wen,
  input  logic                             i_clr_req,
  output logic                             o_busy,
  input  logic                             i_dbg_req,
  input  logic                             i_dbg_we,
  input  logic [ADDR_WIDTH-1:0]            i_dbg_addr,
  input  logic [DATA_WIDTH-1:0]            i_dbg_wdata,
  output logic [DATA_WIDTH-1:0]            o_dbg_rdata,
  output logic                             o_dbg_ack
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, DBG_ACK = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic idle, pipe_we, dbg_take, dbg_we;
  assign idle     = state_q == IDLE;
  assign pipe_we  = i_wen && state_q != CLEAR && i_waddr != '0;
  assign dbg_take = idle && !i_clr_req && i_dbg_req;
  // a same-cycle pipeline write to the debug target wins over the debug write
  assign dbg_we   = dbg_take && i_dbg_we && i_dbg_addr != '0 && !(i_wen && i_waddr == i_dbg_addr);
  assign o_busy      = state_q == CLEAR;
  assign o_dbg_ack   = state_q == DBG_ACK;
  assign o_dbg_rdata = dbg_rdata_q;
  always_comb begin
    mem_d = mem_q;
    if (pipe_we) mem_d[i_waddr] = i_wdata;
    if (dbg_we) mem_d[i_dbg_addr] = i_dbg_wdata;
    if (state_q == CLEAR) mem_d[cnt_q] = '0;
    mem_d[0] = '0;
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dbg_rdata_d = dbg_rdata_q;
    if (idle) begin
      state_d = i_clr_req ? CLEAR : i_dbg_req ? DBG_ACK : IDLE;
      cnt_d   = i_clr_req ? ADDR_WIDTH'(1) : cnt_q;
      if (dbg_take && !i_dbg_we) dbg_rdata_d = i_dbg_addr == '0 ? '0 : mem_q[i_dbg_addr];
    end else if (state_q == CLEAR) begin
      state_d = cnt_q == '1 ? IDLE : CLEAR;
      cnt_d   = cnt_q + ADDR_WIDTH'(1);
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dbg_rdata_q <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_q       <= mem_d;
    end
  end
  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = i_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = a == '0 ? '0 :
      (BYPASS != 0 && i_wen && idle && i_waddr == a) ? i_wdata : mem_q[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, bypass and non-bypass instances on shared stimulus
module tb_regfile_mp;
  logic        clk = 0, rst = 1;
  logic [9:0]  raddr = '0;
  logic [63:0] rbp, rnb;
  logic [4:0]  waddr = '0, dbg_addr = '0;
  logic [31:0] wdata = '0, dbg_wdata = '0, dbg_rdata, dbg_rdata0;
  logic        wen = 0, clr_req = 0, busy, busy0, dbg_req = 0, dbg_we = 0, ack, ack0;
  int          n_chk = 0, n_err = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rbp), .i_waddr(waddr), .i_wdata(wdata),
    .i_wen(wen), .i_clr_req(clr_req), .o_busy(busy), .i_dbg_req(dbg_req), .i_dbg_we(dbg_we),
    .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(dbg_rdata), .o_dbg_ack(ack)
  );
  regfile_mp #(.BYPASS(0)) dut0 (
    .clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rnb), .i_waddr(waddr), .i_wdata(wdata),
    .i_wen(wen), .i_clr_req(clr_req), .o_busy(busy0), .i_dbg_req(dbg_req), .i_dbg_we(dbg_we),
    .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(dbg_rdata0), .o_dbg_ack(ack0)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic exp_push(string tag, logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic obs(logic [31:0] act);
    if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    else chk(tag_q.pop_front(), act, exp_q.pop_front());
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(logic [63:0] bus, int p);
    return bus[p*32 +: 32];
  endfunction

  task automatic rd_chk(string tag, int p, logic [4:0] a, logic [31:0] v);
    raddr[p*5 +: 5] = a;
    exp_push(tag, v);
    #1;
    obs(rd(rbp, p));
  endtask

  task automatic pipe_wr(logic [4:0] a, logic [31:0] d);
    wen = 1; waddr = a; wdata = d;
    step;
    wen = 0;
  endtask

  task automatic dbg_read(logic [4:0] a);
    dbg_req = 1; dbg_we = 0; dbg_addr = a;
    step;
    dbg_req = 0;
  endtask

  initial begin
    int n, acks;
    step; step;
    rst = 0;
    exp_push("rst_busy", 0);  obs(32'(busy));
    exp_push("rst_ack", 0);   obs(32'(ack));
    exp_push("rst_dbg", 0);   obs(dbg_rdata);
    rd_chk("rst_x5", 0, 5, 0);
    step;
    pipe_wr(5, 32'hDEADBEEF);
    rd_chk("x5_p0", 0, 5, 32'hDEADBEEF);
    rd_chk("x5_p1", 1, 5, 32'hDEADBEEF);
    step;
    wen = 1; waddr = 0; wdata = 32'h1234;
    rd_chk("x0_bypass", 0, 0, 0);
    step;
    wen = 0;
    rd_chk("x0_after", 0, 0, 0);
    step;
    wen = 1; waddr = 7; wdata = 32'hA5A5A5A5;
    rd_chk("byp_p1", 1, 7, 32'hA5A5A5A5);
    exp_push("nobyp_p1", 0); obs(rd(rnb, 1));
    step;
    wen = 0;
    rd_chk("x7_after", 1, 7, 32'hA5A5A5A5);
    exp_push("x7_after_nb", 32'hA5A5A5A5); obs(rd(rnb, 1));
    step;
    for (int i = 1; i < 32; i++) pipe_wr(5'(i), 32'(i));
    rd_chk("fill_x17", 0, 17, 17);
    step;
    clr_req = 1;
    step;
    clr_req = 0;
    wen = 1; waddr = 31; wdata = 32'hFFFFFFFF;
    raddr = {5'd31, 5'd1};
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 5) begin
        #1;
        exp_push("mid_x1", 0);   obs(rd(rbp, 0));
        exp_push("mid_x31", 31); obs(rd(rbp, 1));
      end
      step;
    end
    wen = 0;
    exp_push("busy_cycles", 31); obs(32'(n));
    for (int i = 0; i < 32; i++) begin
      rd_chk($sformatf("clr_x%0d", i), 0, 5'(i), 0);
      step;
    end
    pipe_wr(9, 32'h99);
    dbg_read(0);
    exp_push("dbg_rd_x0", 0); obs(dbg_rdata);
    step;
    dbg_read(9);
    exp_push("dbg_ack", 1);     obs(32'(ack));
    exp_push("dbg_rd_x9", 32'h99); obs(dbg_rdata);
    step;
    exp_push("dbg_ack_one", 0); obs(32'(ack));
    dbg_req = 1; dbg_we = 1; dbg_addr = 9; dbg_wdata = 32'h55;
    wen = 1; waddr = 9; wdata = 32'h77;
    step;
    wen = 0; dbg_req = 0;
    exp_push("dbg_wr_ack", 1); obs(32'(ack));
    exp_push("dbg_rd_hold", 32'h99); obs(dbg_rdata);
    step;
    rd_chk("x9_pipe_wins", 0, 9, 32'h77);
    step;
    dbg_req = 1; dbg_we = 1; dbg_addr = 10; dbg_wdata = 32'h1010;
    step;
    dbg_req = 0;
    step;
    rd_chk("x10_dbg_wr", 1, 10, 32'h1010);
    step;
    dbg_req = 1; dbg_we = 0; dbg_addr = 10; clr_req = 1;
    step;
    clr_req = 0;
    exp_push("prio_busy", 1); obs(32'(busy));
    n = 0; acks = 0;
    while (busy && n < 100) begin
      n++;
      acks += int'(ack);
      step;
    end
    exp_push("prio_busy_cycles", 31); obs(32'(n));
    exp_push("prio_no_ack_busy", 0);  obs(32'(acks));
    exp_push("prio_ack_idle", 0);     obs(32'(ack));
    step;
    exp_push("prio_ack", 1);          obs(32'(ack));
    exp_push("prio_rdata", 0);        obs(dbg_rdata);
    dbg_addr = 5; acks = 0;
    repeat (4) begin
      step;
      acks += int'(ack);
    end
    dbg_req = 0;
    exp_push("b2b_acks", 2); obs(32'(acks));
    step;
    pipe_wr(20, 20);
    pipe_wr(31, 31);
    dbg_read(31);
    exp_push("dbg_rd_x31", 31); obs(dbg_rdata);
    step;
    clr_req = 1;
    step;
    clr_req = 0;
    repeat (9) step;
    rst = 1;
    step;
    rst = 0;
    exp_push("rstclr_busy", 0); obs(32'(busy));
    exp_push("rstclr_ack", 0);  obs(32'(ack));
    exp_push("rstclr_dbg", 0);  obs(dbg_rdata);
    rd_chk("rstclr_x20", 0, 20, 0);
    rd_chk("rstclr_x31", 1, 31, 0);
    step;
    wen = 1; waddr = 3; wdata = 32'h33;
    rd_chk("rstclr_idle_byp", 0, 3, 32'h33);
    step;
    wen = 0;
    chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
